// File: rtl/fetch_redirect_unit.sv
// IF stage: owns pc_F, issues in-order imem fetches, buffers responses
// and drives the IF/ID register; a taken decode redirect flushes wrong-path work.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FQ_DEPTH        = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_src_D,
  input  logic [31:0] PC_Target_D,
  input  logic        stall_D,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC_plus4_D,
  output logic        valid_D
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FAW = $clog2(FQ_DEPTH);
  localparam int FCW = $clog2(FQ_DEPTH + 1);
  localparam int SW  = ((OCW > FCW) ? OCW : FCW) + 1;
  localparam logic [TAW-1:0] TAG_LAST = TAW'(MAX_OUTSTANDING - 1);
  localparam logic [OCW-1:0] OUT_MAX  = OCW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0]  FQ_CAP   = SW'(FQ_DEPTH);

  logic [31:0]    pc_f;
  logic           epoch;

  logic [31:0]    tag_pc [MAX_OUTSTANDING];
  logic           tag_ep [MAX_OUTSTANDING];
  logic [TAW-1:0] tag_wr;
  logic [TAW-1:0] tag_rd;
  logic [OCW-1:0] out_cnt;
  logic [OCW-1:0] cur_cnt;

  logic [31:0]    fq_pc  [FQ_DEPTH];
  logic [31:0]    fq_ins [FQ_DEPTH];
  logic [FAW-1:0] fq_wr;
  logic [FAW-1:0] fq_rd;
  logic [FCW-1:0] fq_cnt;

  logic           redirect;
  logic           issue;
  logic           rsp_pop;
  logic           rsp_cur;
  logic           rsp_live;
  logic           load;
  logic           use_head;
  logic           bypass;
  logic           fq_push;
  logic [SW-1:0]  credit;
  logic [31:0]    rsp_pc;

  // Redirect, issue credit, response routing and IF/ID source select.
  always_comb begin
    redirect       = PC_src_D && valid_D && !stall_D;
    rsp_pop        = imem_rsp_valid && (out_cnt != '0);
    rsp_cur        = rsp_pop && (tag_ep[tag_rd] == epoch);
    rsp_live       = rsp_cur && !redirect;
    rsp_pc         = tag_pc[tag_rd];
    credit         = SW'(cur_cnt) + SW'(fq_cnt);
    imem_req_valid = !rst && !redirect
                     && (out_cnt < OUT_MAX)
                     && (credit < FQ_CAP);
    imem_req_addr  = pc_f;
    issue          = imem_req_valid && imem_req_ready;
    load           = !stall_D && !redirect;
    use_head       = load && (fq_cnt != '0);
    bypass         = load && (fq_cnt == '0) && rsp_live;
    fq_push        = rsp_live && !bypass;
  end

  // Fetch PC and epoch: restart at the aligned target on redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f  <= RESET_PC;
      epoch <= 1'b0;
    end else if (redirect) begin
      pc_f  <= PC_Target_D & ~32'd3;
      epoch <= !epoch;
    end else if (issue) begin
      pc_f  <= pc_f + 32'd4;
    end
  end

  // Tag FIFO pointers and in-flight counters; tags survive redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr  <= '0;
      tag_rd  <= '0;
      out_cnt <= '0;
      cur_cnt <= '0;
    end else begin
      if (issue)
        tag_wr <= (tag_wr == TAG_LAST) ? '0 : tag_wr + 1'b1;
      if (rsp_pop)
        tag_rd <= (tag_rd == TAG_LAST) ? '0 : tag_rd + 1'b1;
      if (issue && !rsp_pop)
        out_cnt <= out_cnt + 1'b1;
      else if (!issue && rsp_pop)
        out_cnt <= out_cnt - 1'b1;
      if (redirect)
        cur_cnt <= '0;
      else if (issue && !rsp_cur)
        cur_cnt <= cur_cnt + 1'b1;
      else if (!issue && rsp_cur)
        cur_cnt <= cur_cnt - 1'b1;
    end
  end

  // Tag storage: address and epoch of each accepted request.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_pc[tag_wr] <= pc_f;
      tag_ep[tag_wr] <= epoch;
    end
  end

  // Fetch queue control: emptied on reset or redirect.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      fq_wr  <= '0;
      fq_rd  <= '0;
      fq_cnt <= '0;
    end else begin
      if (fq_push)
        fq_wr <= fq_wr + 1'b1;
      if (use_head)
        fq_rd <= fq_rd + 1'b1;
      if (fq_push && !use_head)
        fq_cnt <= fq_cnt + 1'b1;
      else if (!fq_push && use_head)
        fq_cnt <= fq_cnt - 1'b1;
    end
  end

  // Fetch queue storage: current-epoch responses not bypassed.
  always_ff @(posedge clk) begin
    if (fq_push) begin
      fq_pc[fq_wr]  <= rsp_pc;
      fq_ins[fq_wr] <= imem_rsp_data;
    end
  end

  // IF/ID register: queue head first, else bypass, else bubble.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      valid_D    <= 1'b0;
      instr_D    <= NOP;
      PC_D       <= 32'd0;
      PC_plus4_D <= 32'd4;
    end else if (use_head) begin
      valid_D    <= 1'b1;
      instr_D    <= fq_ins[fq_rd];
      PC_D       <= fq_pc[fq_rd];
      PC_plus4_D <= fq_pc[fq_rd] + 32'd4;
    end else if (bypass) begin
      valid_D    <= 1'b1;
      instr_D    <= imem_rsp_data;
      PC_D       <= rsp_pc;
      PC_plus4_D <= rsp_pc + 32'd4;
    end else if (load) begin
      valid_D    <= 1'b0;
      instr_D    <= NOP;
    end
  end

endmodule
